// File: rtl/timer_pkg.sv
// Shared constants for the UART bit-period timer and the TX frame sequencer.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // 217 cycles at 50 MHz gives a 4.34 us bit period.
   localparam logic [7:0] CLKS_434US = 8'd217;

endpackage

// File: rtl/bit_period_timer.sv
// Free-running bit-period counter (0..CLKS_PER_BIT-1) with a combinational
// rollover strobe at the top count; clear restarts the period from zero.
module bit_period_timer
   import timer_pkg::*;
#(
   parameter int CLKS_PER_BIT = int'(CLKS_434US)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic rollover
);

   localparam logic [7:0] TOP = 8'(CLKS_PER_BIT - 1);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= 8'd0;
      end else if (count == TOP) begin
         count <= 8'd0;
      end else begin
         count <= count + 8'd1;
      end
   end

   assign rollover = (count == TOP);

endmodule

// File: rtl/uart_tx_bit_sequencer.sv
// UART transmit sequencer: accepts a byte over valid/ready and shifts out
// start bit, DATA_BITS data bits (LSB first) and STOP_BITS stop bits on tx.
module uart_tx_bit_sequencer
   import timer_pkg::*;
#(
   parameter int CLKS_PER_BIT = int'(CLKS_434US),
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done,
   output state_t               state
);

   // Handshake: a byte transfers on any rising edge where tx_valid && tx_ready;
   // tx_ready is high only in IDLE and tx_data is sampled only on that edge.

   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   logic [DATA_BITS-1:0] shreg;
   logic [2:0]           bit_idx;
   logic                 accept;
   logic                 tick;
   logic                 timer_clear;

   assign tx_ready    = (state == IDLE);
   assign busy        = (state != IDLE);
   assign accept      = tx_valid && tx_ready;
   // Restarting the timer on accept makes the start bit a full period.
   assign timer_clear = reset || accept || (state == IDLE);

   bit_period_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (timer_clear),
      .rollover (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         bit_idx <= 3'd0;
         shreg   <= '0;
         tx      <= 1'b1;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (accept) begin
                  shreg   <= tx_data;
                  bit_idx <= 3'd0;
                  tx      <= 1'b0;
                  state   <= START;
               end
            end
            START: begin
               if (tick) begin
                  tx    <= shreg[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  shreg <= shreg >> 1;
                  if (bit_idx == LAST_DATA) begin
                     bit_idx <= 3'd0;
                     tx      <= 1'b1;
                     state   <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     // Next data bit is the one the shift brings into bit 0.
                     tx      <= shreg[1];
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (bit_idx == LAST_STOP) begin
                     bit_idx <= 3'd0;
                     done    <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_bit_sequencer.sv
// Directed bench for uart_tx_bit_sequencer: three instances cover divisor 4,
// the default divisor 217, and two stop bits.
module tb_uart_tx_bit_sequencer;
   import timer_pkg::*;

   logic clk;
   logic reset;

   logic [7:0] d4, d217, d4s2;
   logic       v4, v217, v4s2;
   logic       r4, r217, r4s2;
   logic       t4, t217, t4s2;
   logic       b4, b217, b4s2;
   logic       dn4, dn217, dn4s2;
   state_t     s4, s217, s4s2;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Observation mux: 0 = divisor 4, 1 = divisor 217, 2 = divisor 4 / two stops
   int     sel;
   logic   o_tx, o_ready, o_busy, o_done;
   state_t o_state;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_bit_sequencer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) u_dut4 (
      .clk(clk), .reset(reset), .tx_data(d4), .tx_valid(v4), .tx_ready(r4),
      .tx(t4), .busy(b4), .done(dn4), .state(s4));

   uart_tx_bit_sequencer #(.CLKS_PER_BIT(217), .DATA_BITS(8), .STOP_BITS(1)) u_dut217 (
      .clk(clk), .reset(reset), .tx_data(d217), .tx_valid(v217), .tx_ready(r217),
      .tx(t217), .busy(b217), .done(dn217), .state(s217));

   uart_tx_bit_sequencer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(2)) u_dut4s2 (
      .clk(clk), .reset(reset), .tx_data(d4s2), .tx_valid(v4s2), .tx_ready(r4s2),
      .tx(t4s2), .busy(b4s2), .done(dn4s2), .state(s4s2));

   always_comb begin
      o_tx = t4; o_ready = r4; o_busy = b4; o_done = dn4; o_state = s4;
      if (sel == 1) begin
         o_tx = t217; o_ready = r217; o_busy = b217; o_done = dn217; o_state = s217;
      end else if (sel == 2) begin
         o_tx = t4s2; o_ready = r4s2; o_busy = b4s2; o_done = dn4s2; o_state = s4s2;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   // Called at the negedge following an accept edge (offset 0); walks the frame
   // from start_k, then checks the done cycle and returns on it.
   task automatic expect_frame(input logic [7:0] b, input int nstop, input int cpb,
                               input int start_k);
      int total;
      int idx;
      logic exp_bit;
      total = (1 + 8 + nstop) * cpb;
      for (int k = start_k; k < total; k++) begin
         idx = k / cpb;
         if (idx == 0)      exp_bit = 1'b0;
         else if (idx <= 8) exp_bit = b[idx-1];
         else               exp_bit = 1'b1;
         check($sformatf("frame %0h tx k=%0d", b, k), 32'(o_tx), 32'(exp_bit));
         check($sformatf("frame %0h done low k=%0d", b, k), 32'(o_done), 32'd0);
         next_cycle();
      end
      check("frame done pulse", 32'(o_done), 32'd1);
      check("frame end tx", 32'(o_tx), 32'd1);
      check("frame end ready", 32'(o_ready), 32'd1);
      check("frame end busy", 32'(o_busy), 32'd0);
   endtask

   initial begin
      int low;
      int high;
      int cyc_a;
      int cyc_b;
      sel = 0;
      reset = 1'b1;
      v4 = 1'b1; v217 = 1'b1; v4s2 = 1'b1;
      d4 = 8'h3C; d217 = 8'h3C; d4s2 = 8'h3C;

      // Reset held three cycles with valid high on every instance
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            check($sformatf("reset tx s%0d", s), 32'(o_tx), 32'd1);
            check($sformatf("reset ready s%0d", s), 32'(o_ready), 32'd1);
            check($sformatf("reset busy s%0d", s), 32'(o_busy), 32'd0);
            check($sformatf("reset done s%0d", s), 32'(o_done), 32'd0);
         end
      end
      reset = 1'b0;
      v4 = 1'b0; v217 = 1'b0; v4s2 = 1'b0;
      next_cycle();
      sel = 0;
      #0;
      check("post reset idle", 32'(o_busy), 32'd0);
      check("post reset state", 32'(o_state), 32'(IDLE));

      // Single frame A5, divisor 4
      v4 = 1'b1; d4 = 8'hA5;
      next_cycle();
      v4 = 1'b0;
      check("a5 busy after accept", 32'(o_busy), 32'd1);
      expect_frame(8'hA5, 1, 4, 0);
      next_cycle();
      check("a5 done one cycle", 32'(o_done), 32'd0);

      // Default divisor, all-zero byte: 9 low bits then one high stop bit
      sel = 1;
      v217 = 1'b1; d217 = 8'h00;
      next_cycle();
      v217 = 1'b0;
      low = 0;
      while (o_tx === 1'b0 && low < 3000) begin
         low++;
         next_cycle();
      end
      check("217 low cycles", 32'(low), 32'd1953);
      high = 0;
      while (o_done !== 1'b1 && high < 3000) begin
         high++;
         next_cycle();
      end
      check("217 high before done", 32'(high), 32'd217);
      check("217 done seen", 32'(o_done), 32'd1);
      next_cycle();

      // Back-to-back with valid held: 55 then FF
      sel = 0;
      v4 = 1'b1; d4 = 8'h55;
      next_cycle();
      cyc_a = cyc;
      d4 = 8'hFF;
      expect_frame(8'h55, 1, 4, 0);
      check("b2b idle cycle tx", 32'(o_tx), 32'd1);
      next_cycle();
      cyc_b = cyc;
      v4 = 1'b0;
      check("b2b second accept gap", 32'(cyc_b - cyc_a), 32'd41);
      check("b2b second busy", 32'(o_busy), 32'd1);
      expect_frame(8'hFF, 1, 4, 0);
      next_cycle();

      // Reset during DATA bit 3 abandons the frame
      v4 = 1'b1; d4 = 8'h3C;
      next_cycle();
      v4 = 1'b0;
      repeat (17) next_cycle();
      check("mid state DATA", 32'(o_state), 32'(DATA));
      check("mid tx bit3", 32'(o_tx), 32'd1);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      check("mid reset tx", 32'(o_tx), 32'd1);
      check("mid reset state", 32'(o_state), 32'(IDLE));
      check("mid reset done", 32'(o_done), 32'd0);
      high = 0;
      for (int i = 0; i < 50; i++) begin
         next_cycle();
         if (o_done === 1'b1 || o_busy === 1'b1) high++;
      end
      check("mid reset no done/busy", 32'(high), 32'd0);
      v4 = 1'b1; d4 = 8'hC3;
      next_cycle();
      v4 = 1'b0;
      expect_frame(8'hC3, 1, 4, 0);
      next_cycle();

      // Two stop bits; valid pulsed while busy is ignored
      sel = 2;
      v4s2 = 1'b1; d4s2 = 8'h96;
      next_cycle();
      d4s2 = 8'h00;
      check("s2 ready while busy", 32'(o_ready), 32'd0);
      next_cycle();
      v4s2 = 1'b0;
      expect_frame(8'h96, 2, 4, 1);
      next_cycle();
      check("s2 no second frame", 32'(o_busy), 32'd0);
      check("s2 idle tx", 32'(o_tx), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout: simulation exceeded time budget");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_tx_bit_sequencer.md
# uart_tx_bit_sequencer

Frame sequencer that owns a bit-period timer and uses it to shift one byte out on a serial line: start bit, DATA_BITS data bits LSB first, then STOP_BITS stop bits. It sits between a byte producer (valid/ready handshake) and the TX pin. It clears its timer at every frame start so the start bit is always a full bit period. With the default divisor of 217 cycles, a bit lasts 4.34 µs at 50 MHz.

## Interface
- CLKS_PER_BIT, 217: bit period in clk cycles; legal range 2–255.
- DATA_BITS, 8: data bits per frame; legal range 5–8.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
- tx_valid  input  1  producer has a byte.
- tx_ready  output  1  sequencer is idle and will accept a byte.
- tx  output  1  serial line, registered; idles high.
- busy  output  1  frame in progress (state ≠ IDLE).
- done  output  1  one-cycle pulse when the last stop bit completes.

## Operation
- **States:** IDLE, START, DATA, STOP.
- **Handshake:** accepted when tx_valid && tx_ready at a clock edge.
  - On that edge: tx_data is latched into the shift register, the timer count is cleared to 0, bit_idx is cleared to 0, and the state goes to START.
  - tx_ready = (state == IDLE); it is combinational from the state register.
  - tx_data and tx_valid are ignored outside IDLE.
- **Timer:** 8-bit count, 0..CLKS_PER_BIT-1, then wraps to 0.
  - tick = (count == CLKS_PER_BIT-1), combinational.
  - The count is held at 0 in IDLE.
- **START:** tx = 0. On tick, go to DATA.
- **DATA:** tx = shreg[0]. On tick:
  - shift shreg right by one and increment bit_idx;
  - when bit_idx == DATA_BITS-1, go to STOP with bit_idx = 0.
- **STOP:** tx = 1. On tick:
  - if bit_idx == STOP_BITS-1, go to IDLE and pulse done;
  - otherwise increment bit_idx.
- **Reset** wins over everything, including mid-frame. On the reset edge: state = IDLE, count = 0, bit_idx = 0, shreg = 0, tx = 1, done = 0.
  - A partially sent frame is abandoned.
  - The line is high from the cycle after the reset edge.
- **Reset values:** tx = 1, tx_ready = 1, busy = 0, done = 0.

## Timing
- tx is registered, so it changes on the edge that accepts the byte or advances a bit. The first low cycle of tx is the cycle after the accept edge.
- Each bit lasts exactly CLKS_PER_BIT cycles on tx.
- The frame lasts (1 + DATA_BITS + STOP_BITS) × CLKS_PER_BIT cycles, measured from the accept edge to the edge that returns to IDLE.
- done is high for exactly one cycle: the first cycle in IDLE after the frame.
- **Back-to-back frames:** if tx_valid is held high, the next accept happens on the edge after returning to IDLE. The line therefore shows exactly one extra idle-high cycle between frames. The frame period is (1 + DATA_BITS + STOP_BITS) × CLKS_PER_BIT + 1 cycles.
- **Simultaneous events:** reset asserted together with tx_valid means no accept.
- done and tx_ready are both high in the IDLE cycle after a frame. A new byte may be accepted in that same cycle.

## Structure
- **Shared timer package (timer_pkg):**
  - state enum constants: IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  - default divisor constant CLKS_434US = 8'd217.
- **Sub-module:** bit_period_timer.
  - Ports: clk, reset, clear, rollover. Parameter: CLKS_PER_BIT.
  - It counts 0..CLKS_PER_BIT-1 and raises a combinational rollover at the top count.
  - clear acts like reset but is driven by the sequencer.
  - The sequencer drives clear = (reset || accept || state == IDLE).

## Test plan
- **Reset:** assert reset 3 cycles with tx_valid = 1. Required: tx = 1, tx_ready = 1, busy = 0, done = 0 throughout, and no frame starts.
- **Single frame, CLKS_PER_BIT = 4, byte 8'hA5.**
  - Required tx sequence, 4 cycles per bit: 0, then 1,0,1,0,0,1,0,1, then 1.
  - done pulses exactly 40 cycles after the accept edge.
- **Default divisor 217, byte 8'h00:** tx low for exactly 9 × 217 = 1953 cycles, then high for 217 cycles before done.
- **Back-to-back, CLKS_PER_BIT = 4, tx_valid held high with 8'h55 then 8'hFF:** exactly one idle-high cycle between the frames; second accept occurs 41 cycles after the first.
- **Reset mid-frame:** assert reset during DATA bit 3. Required: tx = 1 the next cycle, state IDLE, no done pulse, and a fresh byte then sends a complete, correct frame.
- **STOP_BITS = 2, CLKS_PER_BIT = 4:** stop high for 8 cycles before done; tx_valid pulsed while busy is ignored (tx_ready = 0).
